// File: rtl/spram_pkg.sv
// spram_pkg: shared helpers and encodings for the single-port SRAM front-end.
package spram_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_SERVE = 1'b1;

    typedef enum logic {
        S_INIT  = ST_INIT,
        S_SERVE = ST_SERVE
    } state_e;

    localparam logic CEN_ON    = 1'b0;
    localparam logic WEN_WRITE = 1'b0;

endpackage

// File: rtl/spram_rsp_fifo.sv
// spram_rsp_fifo: synchronous first-word-fall-through FIFO with occupancy count.
module spram_rsp_fifo
    import spram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && valid;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/spram_ctrl.sv
// spram_ctrl: init sweep plus valid/ready front-end for a single-port SRAM.
// Define SPRAM_CTRL_PERF_EN to add saturating read/write request counters.
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int                   MEM_WIDTH  = 32,
    parameter int                   MEM_DEPTH  = 4096,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE = MEM_WIDTH'(1),
    parameter int                   RSP_DEPTH  = 2,
    localparam int AW = clog2(MEM_DEPTH),
    localparam int CW = clog2(RSP_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [AW-1:0]        req_addr,
    input  logic [MEM_WIDTH-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MEM_WIDTH-1:0] rsp_data,
    output logic                 init_done,
    output logic                 mem_cen,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_addr,
    output logic [MEM_WIDTH-1:0] mem_d,
`ifdef SPRAM_CTRL_PERF_EN
    output logic [31:0]          perf_rd_cnt,
    output logic [31:0]          perf_wr_cnt,
`endif
    input  logic [MEM_WIDTH-1:0] mem_q
);

    localparam logic [AW:0] LAST = (AW + 1)'(MEM_DEPTH - 1);

    state_e        state;
    state_e        state_nxt;
    logic [AW:0]   ptr;
    logic          rd_inflight;
    logic          accept;
    logic          rd_accept;
    logic          rd_ok;
    logic          pop;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   used;

    assign init_done = (state == S_SERVE);
    assign pop       = rsp_valid & rsp_ready;

    // A head leaving this cycle frees its slot for the read issued now.
    assign used  = {1'b0, fifo_cnt} - (CW + 1)'(pop) + (CW + 1)'(rd_inflight);
    assign rd_ok = used < (CW + 1)'(RSP_DEPTH);

    assign req_ready = (state == S_SERVE) & (req_wr | rd_ok);
    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            ptr         <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= rd_accept;
            if (state == S_INIT) ptr <= ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_cen   = ~CEN_ON;
        mem_wen   = ~WEN_WRITE;
        mem_addr  = req_addr;
        mem_d     = req_data;
        unique case (1'b1)
            (state == S_INIT): begin
                // Port stays idle while reset is held.
                if (rst_n) begin
                    mem_cen = CEN_ON;
                    mem_wen = WEN_WRITE;
                end
                mem_addr = ptr[AW-1:0];
                mem_d    = INIT_VALUE;
                if (ptr == LAST) state_nxt = S_SERVE;
            end
            (state == S_SERVE): begin
                mem_cen = accept ? CEN_ON : ~CEN_ON;
                mem_wen = req_wr ? WEN_WRITE : ~WEN_WRITE;
            end
        endcase
    end

    spram_rsp_fifo #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight),
        .push_data (mem_q),
        .pop       (pop),
        .head      (rsp_data),
        .valid     (rsp_valid),
        .count     (fifo_cnt)
    );

`ifdef SPRAM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_cnt <= '0;
            perf_wr_cnt <= '0;
        end else begin
            if (rd_accept && perf_rd_cnt != '1)
                perf_rd_cnt <= perf_rd_cnt + 1'b1;
            if (accept && req_wr && perf_wr_cnt != '1)
                perf_wr_cnt <= perf_wr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: scoreboard bench for spram_ctrl with a behavioural SRAM.
module tb_spram_ctrl;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          init_done;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_d;
    logic [W-1:0]  mem_q;
`ifdef SPRAM_CTRL_PERF_EN
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_wr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] shadow [D];
    logic [W-1:0] sram [D];

    always #5 clk = ~clk;

    spram_ctrl #(
        .MEM_WIDTH  (W),
        .MEM_DEPTH  (D),
        .INIT_VALUE (32'h1),
        .RSP_DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
`ifdef SPRAM_CTRL_PERF_EN
        .perf_rd_cnt (perf_rd_cnt),
        .perf_wr_cnt (perf_wr_cnt),
`endif
        .mem_q     (mem_q)
    );

    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_addr] <= mem_d;
            else          mem_q <= sram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
            end else begin
                check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic try_req(input bit wr, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input int budget,
                           output bit acc);
        acc = 1'b0;
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = a;
        req_data = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
            stalls++;
        end
        if (acc) begin
            if (wr) shadow[a] = d;
            else    exp_q.push_back(shadow[a]);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end else begin
            req_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input bit wr, input logic [AW-1:0] a,
                          input logic [W-1:0] d);
        bit acc;
        try_req(wr, a, d, 50, acc);
        check("req_accept", 64'(acc), 64'(1));
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < D; i++) shadow[i] = 32'h1;

        // reset state
        repeat (2) @(negedge clk);
        check("reset_outs", {59'd0, req_ready, rsp_valid, init_done, mem_cen, mem_wen},
              64'b00011);

        // init sweep with a stray read request held high
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b1;
        for (int c = 0; c < D; c++) begin
            @(negedge clk);
            check($sformatf("init_cyc%0d", c),
                  {mem_cen, mem_wen, mem_addr, mem_d, req_ready, init_done},
                  {1'b0, 1'b0, 4'(c), 32'h1, 1'b0, 1'b0});
            if (c == D - 1) req_valid = 1'b0;
        end
        @(negedge clk);
        check("init_done_rise", 64'(init_done), 64'(1));
        check("serve_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;

        // write then read back-to-back, with latency check
        do_req(1'b1, 4'd3, 32'hDEADBEEF);
        do_req(1'b0, 4'd3, '0);
        @(negedge clk);
        check("rd_lat_n1", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("rd_lat_n2", 64'(rsp_valid), 64'(1));
        check("rd_lat_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        @(posedge clk);
        #1;
        do_req(1'b0, 4'd5, '0);

        for (int i = 0; i < D; i++)
            do_req(1'b1, 4'(i), 32'h1000 + 32'(i) * 3);

        // backpressure: two reads fit, further reads stall, writes still go
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        try_req(1'b0, 4'd0, '0, 5, acc);
        check("bp_rd0", 64'(acc), 64'(1));
        try_req(1'b0, 4'd1, '0, 5, acc);
        check("bp_rd1", 64'(acc), 64'(1));
        try_req(1'b0, 4'd2, '0, 5, acc);
        check("bp_rd2_blocked", 64'(acc), 64'(0));
        try_req(1'b0, 4'd3, '0, 5, acc);
        check("bp_rd3_blocked", 64'(acc), 64'(0));
        try_req(1'b1, 4'd9, 32'hCAFE0009, 5, acc);
        check("bp_wr", 64'(acc), 64'(1));
        @(negedge clk);
        check("bp_hold_valid", 64'(rsp_valid), 64'(1));
        check("bp_hold_data", 64'(rsp_data), 64'(32'h1000));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        do_req(1'b0, 4'd2, '0);
        do_req(1'b0, 4'd3, '0);

        // streaming
        repeat (4) @(posedge clk);
        #1;
        stalls = 0;
        for (int i = 0; i < 100; i++) do_req(1'b0, 4'(i % D), '0);
        check("stream_stalls", 64'(stalls), 64'(0));
        repeat (4) @(negedge clk);
        check("stream_drained", 64'(exp_q.size()), 64'(0));
        check("stream_idle", 64'(rsp_valid), 64'(0));

        // reset with two responses queued
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_req(1'b0, 4'd4, '0);
        do_req(1'b0, 4'd7, '0);
        repeat (3) @(negedge clk);
        check("rst_pre_valid", 64'(rsp_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(rsp_valid), 64'(0));
        check("rst_async_done", 64'(init_done), 64'(0));
        check("rst_async_cen", 64'(mem_cen), 64'(1));
        exp_q.delete();
        for (int i = 0; i < D; i++) shadow[i] = 32'h1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reinit_addr0", {mem_cen, mem_wen, mem_addr}, {1'b0, 1'b0, 4'd0});
        for (int i = 0; i < 40; i++) begin
            if (init_done) break;
            @(negedge clk);
        end
        check("reinit_done", 64'(init_done), 64'(1));
        check("reinit_no_rsp", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;

        // 7 reads and 5 writes after reset
        do_req(1'b0, 4'd4, '0);
        for (int i = 0; i < 5; i++)
            do_req(1'b1, 4'(10 + i), 32'hA500 + 32'(i));
        for (int i = 0; i < 6; i++)
            do_req(1'b0, 4'(9 + i), '0);
`ifdef SPRAM_CTRL_PERF_EN
        @(negedge clk);
        check("perf_rd", 64'(perf_rd_cnt), 64'(7));
        check("perf_wr", 64'(perf_wr_cnt), 64'(5));
`endif

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("final_drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
